branch_redirect_ctrl: RTL and testbench

Fetch-redirect controller that sequences the PC register and the pipeline flush around branch resolution. Each cycle it selects the next fetch PC from the sequential, predicted-taken and corrected-target sources, and honours hazard stalls. On a resolved misprediction it runs a multi-cycle flush sequence that holds the younger pipeline registers in reset while the corrected target is fetched. It sits between the branch predictor/evaluator outputs and the IF-stage PC register, and keeps saturating performance counters for redirects and mispredictions.

---
 rtl/branch_redirect_ctrl.sv | 106 ++++++++++
 tb/tb_branch_redirect_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Fetch-redirect controller: picks the next fetch PC each cycle and sequences the
// multi-cycle pipeline flush that follows a resolved branch misprediction.
module branch_redirect_ctrl #(
  parameter int WordSize   = 32,
  parameter int FlushDepth = 2,
  parameter int CntWidth   = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic                mispredict,
  input  logic [WordSize-1:0] npc_corr,
  input  logic                pred_taken,
  input  logic [WordSize-1:0] pred_pc,
  input  logic [WordSize-1:0] pc,
  output logic [WordSize-1:0] pc_next,
  output logic                pc_we,
  output logic                rstn_out,
  output logic                flush_busy,
  output logic [CntWidth-1:0] redirect_cnt,
  output logic [CntWidth-1:0] mispred_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0]          FLUSH_LOAD = 4'(FlushDepth - 1);
  localparam logic [WordSize-1:0] PC_STEP    = WordSize'(4);
  localparam logic [CntWidth-1:0] CNT_MAX    = '1;
  localparam logic [CntWidth-1:0] CNT_ONE    = CntWidth'(1);

  state_t     state, state_d;
  logic [3:0] flush_left, flush_left_d;
  logic       mis_inc, red_inc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RUN;
      flush_left <= 4'd0;
    end else begin
      state      <= state_d;
      flush_left <= flush_left_d;
    end
  end

  // While rstn is low every output falls back to "hold PC, flush pipeline".
  always_comb begin
    state_d      = state;
    flush_left_d = flush_left;
    pc_next      = pc;
    pc_we        = 1'b0;
    rstn_out     = 1'b0;
    flush_busy   = 1'b0;
    mis_inc      = 1'b0;
    red_inc      = 1'b0;
    if (rstn) begin
      case (state)
        RUN: begin
          if (mispredict) begin
            pc_next      = npc_corr;
            pc_we        = 1'b1;
            flush_busy   = 1'b1;
            mis_inc      = 1'b1;
            flush_left_d = FLUSH_LOAD;
            state_d      = (FlushDepth > 1) ? FLUSH : RUN;
          end else if (stall) begin
            rstn_out = 1'b1;
          end else if (pred_taken) begin
            pc_next  = pred_pc;
            pc_we    = 1'b1;
            rstn_out = 1'b1;
            red_inc  = 1'b1;
          end else begin
            pc_next  = pc + PC_STEP;
            pc_we    = 1'b1;
            rstn_out = 1'b1;
          end
        end
        FLUSH: begin
          flush_busy = 1'b1;
          // Leaving on the count that reaches zero keeps rstn_out low for FlushDepth cycles total.
          if (flush_left <= 4'd1) begin
            flush_left_d = 4'd0;
            state_d      = RUN;
          end else begin
            flush_left_d = flush_left - 4'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_cnt <= '0;
      mispred_cnt  <= '0;
    end else begin
      if (red_inc && (redirect_cnt != CNT_MAX)) redirect_cnt <= redirect_cnt + CNT_ONE;
      if (mis_inc && (mispred_cnt != CNT_MAX))  mispred_cnt  <= mispred_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two instances (deep flush / narrow saturating counters)
// driven by shared directed then random stimulus and checked against a flush-countdown model.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rstn, stall, mispredict, pred_taken;
  logic [31:0] npc_corr, pred_pc, pc;

  logic [31:0] a_pc_next, b_pc_next;
  logic        a_pc_we, a_rstn_out, a_flush_busy;
  logic        b_pc_we, b_rstn_out, b_flush_busy;
  logic [15:0] a_redirect_cnt, a_mispred_cnt;
  logic [3:0]  b_redirect_cnt, b_mispred_cnt;

  branch_redirect_ctrl #(.WordSize(32), .FlushDepth(3), .CntWidth(16)) dut_a (
    .clk(clk), .rstn(rstn), .stall(stall), .mispredict(mispredict), .npc_corr(npc_corr),
    .pred_taken(pred_taken), .pred_pc(pred_pc), .pc(pc), .pc_next(a_pc_next), .pc_we(a_pc_we),
    .rstn_out(a_rstn_out), .flush_busy(a_flush_busy), .redirect_cnt(a_redirect_cnt),
    .mispred_cnt(a_mispred_cnt)
  );

  branch_redirect_ctrl #(.WordSize(32), .FlushDepth(1), .CntWidth(4)) dut_b (
    .clk(clk), .rstn(rstn), .stall(stall), .mispredict(mispredict), .npc_corr(npc_corr),
    .pred_taken(pred_taken), .pred_pc(pred_pc), .pc(pc), .pc_next(b_pc_next), .pc_we(b_pc_we),
    .rstn_out(b_rstn_out), .flush_busy(b_flush_busy), .redirect_cnt(b_redirect_cnt),
    .mispred_cnt(b_mispred_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: per instance, cycles of flush still to come plus event tallies
  int depth [2] = '{3, 1};
  int cmax  [2] = '{65535, 15};
  int rem   [2];
  int mis   [2];
  int red   [2];
  logic [31:0] e_next [2];
  logic        e_we   [2];
  logic        e_rout [2];
  logic        e_busy [2];

  logic [31:0] sa_next;
  logic        sa_we, sa_rout, sa_busy;
  logic [15:0] sa_red, sa_mis;
  logic [3:0]  sb_mis, sb_red;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    for (int i = 0; i < 2; i++) begin
      e_next[i] = pc; e_we[i] = 1'b0; e_rout[i] = 1'b0; e_busy[i] = 1'b0;
      if (!rstn) begin
        e_next[i] = pc;
      end else if (rem[i] > 0) begin
        e_busy[i] = 1'b1;
      end else if (mispredict) begin
        e_next[i] = npc_corr; e_we[i] = 1'b1; e_busy[i] = 1'b1;
      end else if (stall) begin
        e_rout[i] = 1'b1;
      end else if (pred_taken) begin
        e_next[i] = pred_pc; e_we[i] = 1'b1; e_rout[i] = 1'b1;
      end else begin
        e_next[i] = pc + 32'd4; e_we[i] = 1'b1; e_rout[i] = 1'b1;
      end
    end
  endtask

  task automatic compare();
    sa_next = a_pc_next; sa_we = a_pc_we; sa_rout = a_rstn_out; sa_busy = a_flush_busy;
    sa_red = a_redirect_cnt; sa_mis = a_mispred_cnt; sb_mis = b_mispred_cnt; sb_red = b_redirect_cnt;
    check("a_pc_next", 64'(a_pc_next), 64'(e_next[0]));
    check("a_pc_we", 64'(a_pc_we), 64'(e_we[0]));
    check("a_rstn_out", 64'(a_rstn_out), 64'(e_rout[0]));
    check("a_flush_busy", 64'(a_flush_busy), 64'(e_busy[0]));
    check("a_redirect_cnt", 64'(a_redirect_cnt), rstn ? 64'(red[0]) : 64'd0);
    check("a_mispred_cnt", 64'(a_mispred_cnt), rstn ? 64'(mis[0]) : 64'd0);
    check("b_pc_next", 64'(b_pc_next), 64'(e_next[1]));
    check("b_pc_we", 64'(b_pc_we), 64'(e_we[1]));
    check("b_rstn_out", 64'(b_rstn_out), 64'(e_rout[1]));
    check("b_flush_busy", 64'(b_flush_busy), 64'(e_busy[1]));
    check("b_redirect_cnt", 64'(b_redirect_cnt), rstn ? 64'(red[1]) : 64'd0);
    check("b_mispred_cnt", 64'(b_mispred_cnt), rstn ? 64'(mis[1]) : 64'd0);
  endtask

  task automatic update();
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        rem[i] = 0; mis[i] = 0; red[i] = 0;
      end else if (rem[i] > 0) begin
        rem[i]--;
      end else if (mispredict) begin
        if (mis[i] < cmax[i]) mis[i]++;
        rem[i] = depth[i] - 1;
      end else if (!stall && pred_taken) begin
        if (red[i] < cmax[i]) red[i]++;
      end
    end
  endtask

  // driver: one cycle, checked mid-cycle, model advanced at the edge
  task automatic step();
    @(negedge clk);
    predict();
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; mispredict = 1'b0; pred_taken = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin rem[i] = 0; mis[i] = 0; red[i] = 0; end
    rstn = 1'b1; idle(); npc_corr = '0; pred_pc = '0; pc = 32'h100;
    #2 rstn = 1'b0;

    // reset state
    step();
    check("reset_pc_we", 64'(sa_we), 64'd0);
    check("reset_rstn_out", 64'(sa_rout), 64'd0);
    check("reset_pc_next", 64'(sa_next), 64'h100);

    // sequential fetch
    rstn = 1'b1; pc = 32'h100;
    step();
    check("seq_pc_next", 64'(sa_next), 64'h104);
    check("seq_pc_we", 64'(sa_we), 64'd1);
    check("seq_cnts", 64'({sa_red, sa_mis}), 64'd0);

    // predicted taken, then counter visible, plus wrap
    pred_taken = 1'b1; pred_pc = 32'h2000; pc = 32'h104;
    step();
    check("taken_pc_next", 64'(sa_next), 64'h2000);
    idle(); pc = 32'hFFFF_FFFC;
    step();
    check("taken_redirect_cnt", 64'(sa_red), 64'd1);
    check("wrap_pc_next", 64'(sa_next), 64'h0);

    // mispredict with FlushDepth=3, mispredict held high during the flush
    mispredict = 1'b1; npc_corr = 32'h400;
    step();
    check("mis_T_pc_we", 64'(sa_we), 64'd1);
    check("mis_T_rstn_out", 64'(sa_rout), 64'd0);
    pc = 32'h400;
    for (int k = 1; k <= 2; k++) begin
      step();
      check("mis_flush_pc_we", 64'(sa_we), 64'd0);
      check("mis_flush_rstn_out", 64'(sa_rout), 64'd0);
      check("mis_flush_busy", 64'(sa_busy), 64'd1);
    end
    idle();
    step();
    check("mis_run_busy", 64'(sa_busy), 64'd0);
    check("mis_run_pc_next", 64'(sa_next), 64'h404);
    check("mis_ignored_cnt", 64'(sa_mis), 64'd1);

    // mispredict with stall, then stall with pred_taken
    stall = 1'b1; mispredict = 1'b1; npc_corr = 32'h800;
    step();
    check("mis_stall_pc_next", 64'(sa_next), 64'h800);
    check("mis_stall_pc_we", 64'(sa_we), 64'd1);
    idle(); pc = 32'h800;
    step(); step();
    stall = 1'b1; pred_taken = 1'b1; pred_pc = 32'h3000;
    step();
    check("stall_taken_pc_we", 64'(sa_we), 64'd0);
    idle();
    step();
    check("stall_taken_redirect_cnt", 64'(sa_red), 64'd1);

    // reset in the middle of a flush
    mispredict = 1'b1; npc_corr = 32'h500;
    step();
    idle(); pc = 32'h500; rstn = 1'b0;
    step();
    check("rst_mid_rstn_out", 64'(sa_rout), 64'd0);
    check("rst_mid_cnt", 64'(sa_mis), 64'd0);
    step();
    rstn = 1'b1;
    step();
    check("rst_release_pc_next", 64'(sa_next), 64'h504);
    check("rst_release_busy", 64'(sa_busy), 64'd0);

    // saturation of the narrow counters
    mispredict = 1'b1;
    for (int k = 0; k < 20; k++) begin
      npc_corr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step();
    end
    idle(); pred_taken = 1'b1;
    for (int k = 0; k < 20; k++) step();
    idle();
    step();
    check("sat_b_mispred_cnt", 64'(sb_mis), 64'd15);
    check("sat_b_redirect_cnt", 64'(sb_red), 64'd15);

    // random traffic; PC register follows the reference's write-back
    for (int k = 0; k < 400; k++) begin
      rstn       = ($urandom_range(0, 99) >= 2);
      mispredict = ($urandom_range(0, 99) < 15);
      stall      = ($urandom_range(0, 99) < 25);
      pred_taken = ($urandom_range(0, 99) < 30);
      npc_corr   = $urandom;
      pred_pc    = $urandom;
      if ($urandom_range(0, 9) == 0) pc = $urandom;
      step();
      if (e_we[0]) pc = e_next[0];
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
